mode_counter: RTL and testbench

Parametrised, multi-mode successor to the basic free-running counter. Counts up or down between 0 and a runtime limit i_top, with wrap, saturate and one-shot modes, synchronous clear/load, enable and a tick prescaler. Used for game timers (dealer delay, display blink, card-shuffle LFSR seeding) and any place the design needs a bounded, controllable count.

---
 rtl/mode_counter.sv | 153 +++++++++++++++
 tb/tb_mode_counter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mode_counter.sv
// Bounded up/down counter with wrap, saturate and one-shot modes, sync clear/load and enable.
// Define MODE_COUNTER_PRESCALE_EN to add the tick prescaler; otherwise every enabled cycle ticks.
module mode_counter #(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned INCREMENT      = 1,
  parameter int unsigned PRESCALE_WIDTH = 8
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_enable,
  input  logic                      i_clear,
  input  logic                      i_load,
  input  logic [WIDTH-1:0]          i_load_value,
  input  logic [WIDTH-1:0]          i_top,
  input  logic                      i_dir,
  input  logic [1:0]                i_mode,
  input  logic                      i_start,
  input  logic [PRESCALE_WIDTH-1:0] i_prescale,
  output logic [WIDTH-1:0]          o_value,
  output logic                      o_hitTop,
  output logic                      o_atLimit,
  output logic                      o_busy,
  output logic                      o_done
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [WIDTH:0] Inc = (WIDTH + 1)'(INCREMENT);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             hit_q, hit_d;
  logic             done_q, busy_q;
  logic             tick;

`ifdef MODE_COUNTER_PRESCALE_EN
  logic [PRESCALE_WIDTH-1:0] pre_q, pre_d;
  logic                      pre_wrap;

  assign pre_wrap = (pre_q == i_prescale);
  assign tick     = i_enable & pre_wrap;

  always_comb begin
    pre_d = pre_q;
    if (i_clear || i_load) begin
      pre_d = '0;
    end else if (i_enable) begin
      pre_d = pre_wrap ? '0 : pre_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end
`else
  logic unused_prescale;
  assign unused_prescale = ^i_prescale;
  assign tick            = i_enable;
`endif

  // Step arithmetic is one bit wider so value+INCREMENT can never wrap silently.
  logic [WIDTH:0]   val_ext, top_ext, sum, diff;
  logic [WIDTH-1:0] step_next, up_sat, dn_sat;
  logic             step_hit, below, reached, is_oneshot, wrap_mode, apply;

  assign val_ext    = {1'b0, value_q};
  assign top_ext    = {1'b0, i_top};
  assign sum        = val_ext + Inc;
  assign diff       = val_ext - Inc;
  assign below      = (val_ext < Inc);
  assign up_sat     = (sum > top_ext) ? i_top : sum[WIDTH-1:0];
  assign dn_sat     = below ? '0 : diff[WIDTH-1:0];
  assign is_oneshot = (i_mode == 2'b10);
  assign wrap_mode  = !is_oneshot && (i_mode != 2'b01);
  assign apply      = tick && !i_clear && !i_load && (!is_oneshot || state_q == StRun);

  always_comb begin
    step_next = value_q;
    step_hit  = 1'b0;
    if (i_dir) begin
      if (wrap_mode) begin
        step_hit  = (sum > top_ext);
        step_next = step_hit ? '0 : sum[WIDTH-1:0];
      end else begin
        step_next = up_sat;
        step_hit  = (up_sat == i_top) && (value_q != i_top);
      end
    end else begin
      if (wrap_mode) begin
        step_hit  = below;
        step_next = below ? i_top : diff[WIDTH-1:0];
      end else begin
        step_next = dn_sat;
        step_hit  = (dn_sat == '0) && (value_q != '0);
      end
    end
    reached = i_dir ? (step_next == i_top) : (step_next == '0);
  end

  always_comb begin
    value_d = value_q;
    hit_d   = 1'b0;
    state_d = state_q;
    if (i_clear) begin
      value_d = '0;
      state_d = StIdle;
    end else begin
      if (i_load) begin
        value_d = (i_load_value > i_top) ? i_top : i_load_value;
      end else if (apply) begin
        value_d = step_next;
        hit_d   = step_hit;
      end
      if (!is_oneshot) begin
        state_d = StIdle;
      end else begin
        unique case (state_q)
          StIdle:  if (i_start) state_d = StRun;
          StRun:   if (apply && reached) state_d = StDone;
          StDone:  state_d = StIdle;
          default: state_d = StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= StIdle;
      value_q <= '0;
      hit_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      hit_q   <= hit_d;
      done_q  <= (state_d == StDone);
      busy_q  <= (state_d == StRun);
    end
  end

  assign o_value   = value_q;
  assign o_hitTop  = hit_q;
  assign o_done    = done_q;
  assign o_busy    = busy_q;
  assign o_atLimit = i_dir ? (value_q == i_top) : (value_q == '0);

endmodule

// File: tb/tb_mode_counter.sv
// Self-checking bench for mode_counter: directed scenarios plus randomized traffic, compared
// every cycle against a behavioural integer model (INCREMENT=1 and INCREMENT=3 instances).
module tb_mode_counter;

`ifdef MODE_COUNTER_PRESCALE_EN
  localparam bit PreEn = 1'b1;
`else
  localparam bit PreEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0, clear = 1'b0, load = 1'b0, dir = 1'b1, start = 1'b0;
  logic [15:0] load_value = '0, top = '0;
  logic [1:0]  mode = 2'b00;
  logic [7:0]  prescale = '0;

  logic [15:0] value1, value3;
  logic        hit1, atl1, busy1, done1, hit3, atl3, busy3, done3;
  logic [19:0] vec1, vec3;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  mode_counter #(.WIDTH(16), .INCREMENT(1), .PRESCALE_WIDTH(8)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(enable), .i_clear(clear), .i_load(load),
    .i_load_value(load_value), .i_top(top), .i_dir(dir), .i_mode(mode), .i_start(start),
    .i_prescale(prescale), .o_value(value1), .o_hitTop(hit1), .o_atLimit(atl1),
    .o_busy(busy1), .o_done(done1)
  );

  mode_counter #(.WIDTH(16), .INCREMENT(3), .PRESCALE_WIDTH(8)) dut3 (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(enable), .i_clear(clear), .i_load(load),
    .i_load_value(load_value), .i_top(top), .i_dir(dir), .i_mode(mode), .i_start(start),
    .i_prescale(prescale), .o_value(value3), .o_hitTop(hit3), .o_atLimit(atl3),
    .o_busy(busy3), .o_done(done3)
  );

  assign vec1 = {value1, hit1, done1, busy1, atl1};
  assign vec3 = {value3, hit3, done3, busy3, atl3};

  // Model state: st 0 = idle, 1 = running, 2 = done.
  typedef struct {
    int val;
    int pre;
    int st;
    bit hit;
    bit done;
  } mdl_t;

  mdl_t m1, m3;

  function automatic mdl_t model_reset();
    mdl_t r;
    r.val = 0; r.pre = 0; r.st = 0; r.hit = 0; r.done = 0;
    return r;
  endfunction

  function automatic mdl_t model_step(mdl_t m, int inc);
    mdl_t n;
    int   t, nv, lim;
    bit   os, tk, applied;
    n = m; n.hit = 0; n.done = 0;
    t  = int'(top);
    os = (mode == 2'b10);
    if (clear) begin
      n.val = 0; n.pre = 0; n.st = 0;
      return n;
    end
    tk = enable;
    if (PreEn && enable) begin
      if (m.pre == int'(prescale)) n.pre = 0;
      else begin
        n.pre = (m.pre + 1) % 256;
        tk = 0;
      end
    end
    applied = 0;
    lim = dir ? t : 0;
    if (load) begin
      n.pre = 0;
      n.val = (int'(load_value) > t) ? t : int'(load_value);
    end else if (tk && (!os || m.st == 1)) begin
      applied = 1;
      nv = dir ? m.val + inc : m.val - inc;
      if (!os && mode != 2'b01) begin
        if (dir && nv > t) begin nv = 0; n.hit = 1; end
        else if (!dir && nv < 0) begin nv = t; n.hit = 1; end
      end else begin
        if (dir && nv > t) nv = t;
        if (!dir && nv < 0) nv = 0;
        n.hit = (nv == lim) && (m.val != nv);
      end
      n.val = nv;
    end
    if (!os) n.st = 0;
    else if (m.st == 0) n.st = start ? 1 : 0;
    else if (m.st == 1) n.st = (applied && n.val == lim) ? 2 : 1;
    else n.st = 0;
    n.done = (n.st == 2);
    return n;
  endfunction

  function automatic logic [19:0] exp_vec(mdl_t m);
    logic [15:0] v;
    logic        atl;
    v   = 16'(m.val);
    atl = dir ? (v == top) : (v == 16'd0);
    return {v, m.hit, m.done, m.st == 1, atl};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1 <= model_reset();
      m3 <= model_reset();
    end else begin
      m1 <= model_step(m1, 1);
      m3 <= model_step(m3, 3);
    end
  end

  task automatic quiet();
    clear = 1'b0; load = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; dir = 1'b1; top = 16'd3; enable = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (vec1 !== exp_vec(m1)) $display("FAIL reset: got %h want %h", vec1, exp_vec(m1));
    else passes++;
    checks++;
    if (value1 !== 16'd0 || busy1 !== 1'b0) $display("FAIL reset_value: got %h want 0", value1);
    else passes++;
    rst_n = 1'b1;
  endtask

  task automatic test_wrap_up();
    @(negedge clk);
    clear = 1'b1; top = 16'd3; dir = 1'b1; mode = 2'b00; prescale = '0; enable = 1'b1;
    @(negedge clk);
    quiet();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (vec1 !== exp_vec(m1)) $display("FAIL wrap_up c%0d: got %h want %h", i, vec1, exp_vec(m1));
      else passes++;
    end
  endtask

  task automatic test_sat_down();
    @(negedge clk);
    load = 1'b1; load_value = 16'd5; top = 16'd9; dir = 1'b0; mode = 2'b01; prescale = 8'd2;
    @(negedge clk);
    quiet();
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      checks++;
      if (vec1 !== exp_vec(m1)) $display("FAIL sat_down c%0d: got %h want %h", i, vec1, exp_vec(m1));
      else passes++;
    end
    checks++;
    if (value1 !== 16'd0) $display("FAIL sat_down_floor: got %0d want 0", value1);
    else passes++;
  endtask

  task automatic test_oneshot();
    int dones = 0;
    @(negedge clk);
    clear = 1'b1; top = 16'd4; dir = 1'b1; mode = 2'b10; prescale = '0;
    @(negedge clk);
    clear = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (vec1 !== exp_vec(m1)) $display("FAIL oneshot c%0d: got %h want %h", i, vec1, exp_vec(m1));
      else passes++;
      if (done1) dones++;
      @(negedge clk);
    end
    checks++;
    if (dones != 1 || value1 !== 16'd4 || busy1 !== 1'b0)
      $display("FAIL oneshot_end: got done_count %0d value %0d, want 1 and 4", dones, value1);
    else passes++;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (vec1 !== exp_vec(m1)) $display("FAIL oneshot_re c%0d: got %h want %h", i, vec1, exp_vec(m1));
      else passes++;
    end
  endtask

  task automatic test_priority();
    @(negedge clk);
    mode = 2'b00; dir = 1'b1; top = 16'd20; enable = 1'b1; prescale = '0;
    clear = 1'b1; load = 1'b1; load_value = 16'd7;
    @(negedge clk);
    checks++;
    if (value1 !== 16'd0 || vec1 !== exp_vec(m1)) $display("FAIL prio_clear: got %0d want 0", value1);
    else passes++;
    clear = 1'b0; load = 1'b1; load_value = 16'd9; top = 16'd6;
    @(negedge clk);
    checks++;
    if (value1 !== 16'd6 || vec1 !== exp_vec(m1)) $display("FAIL prio_load: got %0d want 6", value1);
    else passes++;
    quiet();
  endtask

  task automatic test_async_reset();
    int budget = 30;
    @(negedge clk);
    clear = 1'b1; top = 16'd9; dir = 1'b1; mode = 2'b10; prescale = '0; enable = 1'b1;
    @(negedge clk);
    clear = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (value1 != 16'd2 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checks++;
    if (budget == 0) $display("FAIL areset_wait: got value %0d want 2", value1);
    else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (vec1 !== exp_vec(m1) || value1 !== 16'd0 || busy1 !== 1'b0)
      $display("FAIL areset_now: got %h want %h", vec1, exp_vec(m1));
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (vec1 !== exp_vec(m1) || done1 !== 1'b0)
        $display("FAIL areset_idle c%0d: got %h want %h", i, vec1, exp_vec(m1));
      else passes++;
    end
  endtask

  task automatic test_boundary();
    logic [15:0] held;
    @(negedge clk);
    clear = 1'b1; top = 16'd7; dir = 1'b1; mode = 2'b00; prescale = '0; enable = 1'b1;
    @(negedge clk);
    clear = 1'b0; load = 1'b1; load_value = 16'd6;
    @(negedge clk);
    load = 1'b0;
    checks++;
    if (vec3 !== exp_vec(m3)) $display("FAIL bnd_load: got %h want %h", vec3, exp_vec(m3));
    else passes++;
    @(negedge clk);
    checks++;
    if (value3 !== 16'd0 || hit3 !== 1'b1 || vec3 !== exp_vec(m3))
      $display("FAIL bnd_wrap: got %h want value 0 with hit", vec3);
    else passes++;
    enable = 1'b0; prescale = 8'd2;
    held = value3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (value3 !== held || hit3 !== 1'b0 || vec3 !== exp_vec(m3))
        $display("FAIL bnd_freeze c%0d: got %h want %h", i, vec3, exp_vec(m3));
      else passes++;
    end
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (vec3 !== exp_vec(m3)) $display("FAIL bnd_resume c%0d: got %h want %h", i, vec3, exp_vec(m3));
      else passes++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      checks++;
      if (vec1 !== exp_vec(m1) || vec3 !== exp_vec(m3))
        $display("FAIL random c%0d: got %h/%h want %h/%h", i, vec1, vec3, exp_vec(m1), exp_vec(m3));
      else passes++;
      clear      = ($urandom_range(0, 39) == 0);
      load       = ($urandom_range(0, 15) == 0);
      load_value = 16'($urandom_range(0, 25));
      start      = ($urandom_range(0, 5) == 0);
      enable     = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 9) == 0) dir = ~dir;
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 14) == 0) top = 16'($urandom_range(0, 20));
      if ($urandom_range(0, 39) == 0) prescale = 8'($urandom_range(0, 3));
    end
    quiet();
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_sat_down();
    test_oneshot();
    test_priority();
    test_async_reset();
    test_boundary();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
